// File: rtl/vga_pkg.sv
// vga_pkg: 640x480@60 timing defaults, run-state type and RGB332 colour expansion
package vga_pkg;
   localparam int DEF_H_ACTIVE = 640;
   localparam int DEF_H_FP = 16;
   localparam int DEF_H_SYNC = 96;
   localparam int DEF_H_BP = 48;
   localparam int DEF_V_ACTIVE = 480;
   localparam int DEF_V_FP = 10;
   localparam int DEF_V_SYNC = 2;
   localparam int DEF_V_BP = 33;
   localparam int DEF_CLK_DIV = 2;
   localparam int DEF_SCALE_LOG2 = 1;
   localparam int DEF_ADDR_W = 18;
   typedef enum logic [1:0] {IDLE, RUN, DRAIN} run_state_t;
   function automatic logic [23:0] rgb332_expand(input logic [7:0] c);
      return {c[7:5], c[7:5], c[7:6], c[4:2], c[4:2], c[4:3], c[1:0], c[1:0], c[1:0], c[1:0]};
   endfunction
endpackage

// File: rtl/vga_pix_div.sv
// vga_pix_div: system-clock divider producing the one-clock pixel enable
module vga_pix_div #(
   parameter int CLK_DIV = 2
) (
   input  logic clk_50Mhz,
   input  logic rst,
   output logic pix_ce
);
   localparam int W = $clog2(CLK_DIV);
   localparam logic [W-1:0] LAST = W'(CLK_DIV - 1);
   logic [W-1:0] cnt;
   assign pix_ce = cnt == LAST;
   // free-running 0..CLK_DIV-1 count, restarting after each pixel enable
   always_ff @(posedge clk_50Mhz or negedge rst)
      if (!rst) cnt <= '0;
      else cnt <= pix_ce ? '0 : cnt + W'(1);
endmodule

// File: rtl/vga_scan_engine.sv
// vga_scan_engine: VGA scan generator with downscaled framebuffer addressing; VGA_TEST_PATTERN_EN adds colour bars
module vga_scan_engine
   import vga_pkg::*;
#(
   parameter int H_ACTIVE = DEF_H_ACTIVE,
   parameter int H_FP = DEF_H_FP,
   parameter int H_SYNC = DEF_H_SYNC,
   parameter int H_BP = DEF_H_BP,
   parameter int V_ACTIVE = DEF_V_ACTIVE,
   parameter int V_FP = DEF_V_FP,
   parameter int V_SYNC = DEF_V_SYNC,
   parameter int V_BP = DEF_V_BP,
   parameter int CLK_DIV = DEF_CLK_DIV,
   parameter int SCALE_LOG2 = DEF_SCALE_LOG2,
   parameter int ADDR_W = DEF_ADDR_W,
   parameter bit SYNC_POL = 1'b0
) (
   input  logic              clk_50Mhz,
   input  logic              rst,
   input  logic              enable,
   input  logic              pattern,
   input  logic [7:0]        fb_color,
   output logic [ADDR_W-1:0] fb_addr,
   output logic              pix_ce,
   output logic              h_sync,
   output logic              v_sync,
   output logic              video_on,
   output logic [10:0]       pixel_x,
   output logic [10:0]       pixel_y,
   output logic [7:0]        red,
   output logic [7:0]        green,
   output logic [7:0]        blue,
   output logic              frame_start
);
   localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
   localparam logic [10:0] H_LAST = 11'(H_TOTAL - 1);
   localparam logic [10:0] V_LAST = 11'(V_TOTAL - 1);
   localparam logic [10:0] H_ACT = 11'(H_ACTIVE);
   localparam logic [10:0] V_ACT = 11'(V_ACTIVE);
   localparam logic [10:0] HS_BEG = 11'(H_ACTIVE + H_FP);
   localparam logic [10:0] HS_END = 11'(H_ACTIVE + H_FP + H_SYNC);
   localparam logic [10:0] VS_BEG = 11'(V_ACTIVE + V_FP);
   localparam logic [10:0] VS_END = 11'(V_ACTIVE + V_FP + V_SYNC);
   localparam logic [10:0] S_MASK = 11'((1 << SCALE_LOG2) - 1);
   localparam logic [ADDR_W-1:0] FB_W = ADDR_W'(H_ACTIVE >> SCALE_LOG2);
   run_state_t state, state_nxt;
   logic [10:0] h_cnt, v_cnt;
   logic [ADDR_W-1:0] row_base;
   logic scan, h_wrap, f_wrap, row_step, active, hs_win, vs_win;
   logic [7:0] src;
   vga_pix_div #(.CLK_DIV(CLK_DIV)) u_div (.clk_50Mhz(clk_50Mhz), .rst(rst), .pix_ce(pix_ce));
   assign scan = state != IDLE;
   assign h_wrap = pix_ce && scan && h_cnt == H_LAST;
   assign f_wrap = h_wrap && v_cnt == V_LAST;
   assign row_step = ((v_cnt + 11'd1) & S_MASK) == 11'd0;
   assign active = h_cnt < H_ACT && v_cnt < V_ACT;
   assign hs_win = h_cnt >= HS_BEG && h_cnt < HS_END;
   assign vs_win = v_cnt >= VS_BEG && v_cnt < VS_END;
   assign fb_addr = row_base + ADDR_W'(h_cnt >> SCALE_LOG2);
`ifdef VGA_TEST_PATTERN_EN
   localparam int BAR_W = H_ACTIVE / 8;
   localparam int BW = $clog2(BAR_W + 1);
   localparam logic [BW-1:0] BAR_LAST = BW'(BAR_W - 1);
   logic [BW-1:0] bar_cnt;
   logic [2:0] bar_idx;
   assign src = pattern ? {{3{bar_idx[2]}}, {3{bar_idx[1]}}, {2{bar_idx[0]}}} : fb_color;
   // bar index tracks h_cnt in stage 0 so it lines up with fb_color
   always_ff @(posedge clk_50Mhz or negedge rst)
      if (!rst) begin
         bar_cnt <= '0;
         bar_idx <= '0;
      end else if (pix_ce) begin
         bar_cnt <= (!scan || h_wrap || bar_cnt == BAR_LAST) ? '0 : bar_cnt + BW'(1);
         bar_idx <= (!scan || h_wrap) ? 3'd0 : bar_idx + 3'(bar_cnt == BAR_LAST);
      end
`else
   logic unused_pattern;
   assign unused_pattern = pattern;
   assign src = fb_color;
`endif
   // run-state register
   always_ff @(posedge clk_50Mhz or negedge rst)
      if (!rst) state <= IDLE;
      else state <= state_nxt;
   // run control: RUN and DRAIN only differ in that DRAIN falls to IDLE at the frame wrap
   always_comb begin
      state_nxt = state;
      state_nxt = !pix_ce ? state : enable ? RUN : (state == IDLE || f_wrap) ? IDLE : DRAIN;
   end
   // stage 0: scan counters and incremental row base for the downscaled framebuffer
   always_ff @(posedge clk_50Mhz or negedge rst)
      if (!rst) begin
         h_cnt <= '0;
         v_cnt <= '0;
         row_base <= '0;
      end else if (pix_ce && scan) begin
         h_cnt <= h_wrap ? 11'd0 : h_cnt + 11'd1;
         if (h_wrap) begin
            v_cnt <= f_wrap ? 11'd0 : v_cnt + 11'd1;
            row_base <= f_wrap ? '0 : row_step ? row_base + FB_W : row_base;
         end
      end
   // stage 1: registered syncs, coordinates and colour, one pixel behind stage 0
   always_ff @(posedge clk_50Mhz or negedge rst)
      if (!rst) begin
         h_sync <= !SYNC_POL;
         v_sync <= !SYNC_POL;
         video_on <= 1'b0;
         pixel_x <= '0;
         pixel_y <= '0;
         {red, green, blue} <= 24'd0;
         frame_start <= 1'b0;
      end else begin
         frame_start <= pix_ce && scan && h_cnt == 11'd0 && v_cnt == 11'd0;
         if (pix_ce) begin
            h_sync <= scan && hs_win ? SYNC_POL : !SYNC_POL;
            v_sync <= scan && vs_win ? SYNC_POL : !SYNC_POL;
            video_on <= scan && active;
            pixel_x <= h_cnt;
            pixel_y <= v_cnt;
            {red, green, blue} <= scan && active ? rgb332_expand(src) : 24'd0;
         end
      end
endmodule

// File: tb/tb_vga_scan_engine.sv
// tb_vga_scan_engine: randomized scan checks against a pixel-position reference model
module tb_vga_scan_engine;
   localparam int HA = 8, HF = 1, HS = 2, HB = 1, VA = 4, VF = 1, VS = 1, VB = 1;
   localparam int CD = 2, S = 1, AW = 18;
   localparam bit SP = 1'b0;
   localparam int HT = HA + HF + HS + HB, VT = VA + VF + VS + VB, FBW = HA >> S, FRAME = HT * VT;
   logic clk_50Mhz = 0, rst = 0, enable = 0, pattern = 0;
   logic [7:0] fb_color = 0;
   logic [AW-1:0] fb_addr;
   logic pix_ce, h_sync, v_sync, video_on, frame_start;
   logic [10:0] pixel_x, pixel_y;
   logic [7:0] red, green, blue;
   logic [7:0] mem [64];
   bit use_ram = 1, m_run = 0, e_ce = 0, e_vid = 0, e_hs = !SP, e_vs = !SP, e_fs = 0;
   int m_ph = 0, m_p = 0, e_x = 0, e_y = 0, e_addr = 0, cyc = 0, passed = 0, total = 0;
   logic [23:0] e_rgb = 0;

   vga_scan_engine #(.H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB), .V_ACTIVE(VA), .V_FP(VF),
      .V_SYNC(VS), .V_BP(VB), .CLK_DIV(CD), .SCALE_LOG2(S), .ADDR_W(AW), .SYNC_POL(SP)) dut (
      .clk_50Mhz(clk_50Mhz), .rst(rst), .enable(enable), .pattern(pattern), .fb_color(fb_color),
      .fb_addr(fb_addr), .pix_ce(pix_ce), .h_sync(h_sync), .v_sync(v_sync), .video_on(video_on),
      .pixel_x(pixel_x), .pixel_y(pixel_y), .red(red), .green(green), .blue(blue),
      .frame_start(frame_start));

   always #5 clk_50Mhz = ~clk_50Mhz;

   function automatic logic [23:0] expand(input logic [7:0] c);
      return {c[7:5], c[7:5], c[7:6], c[4:2], c[4:2], c[4:3], c[1:0], c[1:0], c[1:0], c[1:0]};
   endfunction

   function automatic logic [7:0] src_at(input int x, input int y);
      int i;
      i = x / (HA / 8);
`ifdef VGA_TEST_PATTERN_EN
      if (pattern) return {{3{i[2]}}, {3{i[1]}}, {2{i[0]}}};
`endif
      return use_ram ? mem[(y >> S) * FBW + (x >> S)] : fb_color;
   endfunction

   task automatic model_reset();
      m_ph = 0; m_p = 0; m_run = 0; e_x = 0; e_y = 0; e_vid = 0;
      e_hs = !SP; e_vs = !SP; e_fs = 0; e_rgb = 0; e_addr = 0;
   endtask

   // one system clock: model the pixel at this edge, then move the RAM model one clock
   task automatic step();
      logic [AW-1:0] a;
      a = fb_addr;
      e_ce = (m_ph == CD - 1);
      e_fs = 0;
      if (e_ce) begin
         e_x = m_p % HT;
         e_y = m_p / HT;
         e_vid = m_run && e_x < HA && e_y < VA;
         e_hs = (m_run && e_x >= HA + HF && e_x < HA + HF + HS) ? SP : !SP;
         e_vs = (m_run && e_y >= VA + VF && e_y < VA + VF + VS) ? SP : !SP;
         e_rgb = e_vid ? expand(src_at(e_x, e_y)) : 24'd0;
         e_fs = m_run && m_p == 0;
         if (m_run) m_p = (m_p + 1) % FRAME;
         m_run = enable || (m_run && m_p != 0);
      end
      m_ph = (m_ph + 1) % CD;
      cyc++;
      @(posedge clk_50Mhz);
      #1;
      if (use_ram) fb_color = mem[a[5:0]];
      e_addr = ((m_p / HT) >> S) * FBW + ((m_p % HT) >> S);
   endtask

   task automatic test_reset();
      logic [AW+50:0] got, want;
      foreach (mem[i]) mem[i] = 8'($urandom);
      rst = 0;
      enable = 1;
      model_reset();
      repeat (3) @(posedge clk_50Mhz);
      #1;
      want = {{AW{1'b0}}, 1'b0, !SP, !SP, 3'b000, 24'd0, 22'd0};
      got = {fb_addr, pix_ce, h_sync, v_sync, video_on, frame_start, 1'b0, red, green, blue, pixel_x, pixel_y};
      total++;
      if (got !== want) $display("FAIL reset_values: got %h want %h", got, want); else passed++;
      rst = 1;
      for (int i = 0; i < 40 && !frame_start; i++) step();
      total++;
      if ({frame_start, video_on, pixel_x, pixel_y, e_fs} !== {2'b11, 22'd0, 1'b1})
         $display("FAIL first_frame_start: fs=%b von=%b x=%0d y=%0d model_fs=%b", frame_start, video_on, pixel_x, pixel_y, e_fs);
      else passed++;
      repeat ($urandom_range(3, 15)) step();
      #2;
      rst = 0;
      #1;
      got = {fb_addr, pix_ce, h_sync, v_sync, video_on, frame_start, 1'b0, red, green, blue, pixel_x, pixel_y};
      total++;
      if (got !== want) $display("FAIL async_reset: got %h want %h", got, want); else passed++;
      model_reset();
      @(posedge clk_50Mhz);
      #1;
      rst = 1;
   endtask

   task automatic test_sync();
      int hf = -1, vf = -1;
      logic ph, pv;
      enable = 1;
      for (int t = 0; t < 3 * FRAME * CD; t++) begin
         ph = h_sync;
         pv = v_sync;
         step();
         total++;
         if ({h_sync, v_sync, pix_ce} !== {e_hs, e_vs, m_ph == CD - 1})
            $display("FAIL sync_model t=%0d: h/v/ce %b%b%b want %b%b%b", t, h_sync, v_sync, pix_ce, e_hs, e_vs, m_ph == CD - 1);
         else passed++;
         if (ph !== SP && h_sync === SP) begin
            if (hf >= 0) begin
               total++;
               if (t - hf !== HT * CD) $display("FAIL hsync_period: %0d clocks want %0d", t - hf, HT * CD); else passed++;
            end
            hf = t;
         end
         if (ph === SP && h_sync !== SP && hf >= 0) begin
            total++;
            if (t - hf !== HS * CD) $display("FAIL hsync_width: %0d clocks want %0d", t - hf, HS * CD); else passed++;
         end
         if (pv !== SP && v_sync === SP) begin
            if (vf >= 0) begin
               total++;
               if (t - vf !== FRAME * CD) $display("FAIL vsync_period: %0d clocks want %0d", t - vf, FRAME * CD); else passed++;
            end
            vf = t;
         end
         if (pv === SP && v_sync !== SP && vf >= 0) begin
            total++;
            if (t - vf !== VS * HT * CD) $display("FAIL vsync_width: %0d clocks want %0d", t - vf, VS * HT * CD); else passed++;
         end
      end
   endtask

   task automatic test_address();
      bit hit53 = 0, hit01 = 0;
      enable = 1;
      for (int t = 0; t < 2 * FRAME * CD; t++) begin
         step();
         total++;
         if (fb_addr !== AW'(e_addr)) $display("FAIL fb_addr p=%0d: got %0d want %0d", m_p, fb_addr, e_addr); else passed++;
         if (m_p == 3 * HT + 5 && !hit53) begin
            hit53 = 1;
            total++;
            if (fb_addr !== AW'(6)) $display("FAIL addr_5_3: got %0d want 6", fb_addr); else passed++;
         end
         if (m_p == HT + 1 && !hit01) begin
            hit01 = 1;
            total++;
            if (fb_addr !== AW'(0)) $display("FAIL addr_row1_base: got %0d want 0", fb_addr); else passed++;
         end
      end
      if (!hit53 || !hit01) begin
         total++;
         $display("FAIL addr_probe_reached: got %b%b want 11", hit53, hit01);
      end
   endtask

   task automatic test_colour();
      logic [7:0] s;
      enable = 1;
      for (int t = 0; t < FRAME * CD; t++) begin
         if (t % CD == 0) pattern = 1'($urandom);
         step();
         total++;
         if ({video_on, red, green, blue} !== {e_vid, e_rgb})
            $display("FAIL colour_ram (%0d,%0d): got %b %h want %b %h", e_x, e_y, video_on, {red, green, blue}, e_vid, e_rgb);
         else passed++;
      end
      pattern = 0;
      use_ram = 0;
      for (int t = 0; t < FRAME * CD; t++) begin
         fb_color = ($urandom_range(0, 2) == 0) ? 8'hE0 : 8'($urandom_range(1, 255));
         s = fb_color;
         step();
         total++;
         if ({video_on, red, green, blue} !== {e_vid, e_rgb})
            $display("FAIL colour_forced (%0d,%0d): got %b %h want %b %h", e_x, e_y, video_on, {red, green, blue}, e_vid, e_rgb);
         else passed++;
         if (e_ce && e_vid && s == 8'hE0) begin
            total++;
            if ({red, green, blue} !== 24'hFF0000) $display("FAIL colour_e0: got %h want ff0000", {red, green, blue}); else passed++;
         end
         if (e_ce && !e_vid) begin
            total++;
            if ({red, green, blue} !== 24'd0) $display("FAIL colour_blank: got %h want 000000", {red, green, blue}); else passed++;
         end
      end
      use_ram = 1;
      step();
      step();
   endtask

   task automatic test_run_control();
      int tgt, f0;
      enable = 1;
      tgt = 2 * HT + $urandom_range(0, HT - 1);
      for (int t = 0; t < 2 * FRAME * CD && m_p != tgt; t++) step();
      enable = 0;
      for (int t = 0; t < 2 * FRAME * CD && m_run; t++) begin
         step();
         total++;
         if ({pixel_x, pixel_y, video_on, h_sync, v_sync, frame_start, red, green, blue} !== {11'(e_x), 11'(e_y), e_vid, e_hs, e_vs, e_fs, e_rgb})
            $display("FAIL drain (%0d,%0d): got x=%0d y=%0d von=%b fs=%b", e_x, e_y, pixel_x, pixel_y, video_on, frame_start);
         else passed++;
      end
      repeat (CD) step();
      for (int t = 0; t < 20; t++) begin
         step();
         total++;
         if ({h_sync, v_sync, video_on, frame_start, pixel_x, pixel_y, fb_addr} !== {!SP, !SP, 2'b00, 22'd0, {AW{1'b0}}})
            $display("FAIL idle t=%0d: h=%b v=%b von=%b fs=%b x=%0d y=%0d addr=%0d", t, h_sync, v_sync, video_on, frame_start, pixel_x, pixel_y, fb_addr);
         else passed++;
      end
      enable = 1;
      for (int t = 0; t < 3 * FRAME * CD && !frame_start; t++) step();
      f0 = cyc;
      tgt = 2 * HT + $urandom_range(0, HT - 1);
      for (int t = 0; t < 2 * FRAME * CD && m_p != tgt; t++) step();
      enable = 0;
      repeat ($urandom_range(4, 30)) step();
      enable = 1;
      for (int t = 0; t < 2 * FRAME * CD; t++) begin
         step();
         total++;
         if ({pixel_x, pixel_y, video_on, h_sync, v_sync, frame_start, red, green, blue} !== {11'(e_x), 11'(e_y), e_vid, e_hs, e_vs, e_fs, e_rgb})
            $display("FAIL reenable (%0d,%0d): got x=%0d y=%0d von=%b fs=%b", e_x, e_y, pixel_x, pixel_y, video_on, frame_start);
         else passed++;
         if (frame_start) break;
      end
      total++;
      if (!frame_start || cyc - f0 != FRAME * CD)
         $display("FAIL no_gap: fs=%b interval %0d clocks want %0d", frame_start, cyc - f0, FRAME * CD);
      else passed++;
   endtask

`ifdef VGA_TEST_PATTERN_EN
   task automatic test_pattern();
      enable = 1;
      pattern = 1;
      foreach (mem[i]) mem[i] = 8'($urandom_range(1, 255));
      repeat (CD) step();
      for (int t = 0; t < FRAME * CD; t++) begin
         step();
         total++;
         if ({video_on, red, green, blue} !== {e_vid, e_rgb})
            $display("FAIL pattern (%0d,%0d): got %h want %h", e_x, e_y, {red, green, blue}, e_rgb);
         else passed++;
         if (e_ce && e_vid && e_x == 0) begin
            total++;
            if ({red, green, blue} !== 24'd0) $display("FAIL pattern_px0: got %h want 000000", {red, green, blue}); else passed++;
         end
         if (e_ce && e_vid && e_x == HA - 1) begin
            total++;
            if ({red, green, blue} !== 24'hFFFFFF) $display("FAIL pattern_last: got %h want ffffff", {red, green, blue}); else passed++;
         end
      end
      pattern = 0;
   endtask
`endif

   initial begin
      test_reset();
      test_sync();
      test_address();
      test_colour();
      test_run_control();
`ifdef VGA_TEST_PATTERN_EN
      test_pattern();
`endif
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule

// File: doc/vga_scan_engine.md
# vga_scan_engine

Parametrised VGA scan generator that replaces the fixed 640x480 controller/pixel-printer pair in the `cpu` top level. It runs from the single system clock with a pixel clock-enable instead of a divided clock. It generates sync/blanking, the framebuffer read address (with power-of-two downscaling), and RGB332 to 24-bit colour expansion. It sits between the processor's shared framebuffer read port and the DE1-SoC VGA DAC pins.

## Interface
Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FP / H_SYNC / H_BP, 16 / 96 / 48, horizontal porch and sync widths in pixels
- V_ACTIVE, 480, visible lines
- V_FP / V_SYNC / V_BP, 10 / 2 / 33, vertical porch and sync widths in lines
- CLK_DIV, 2, system clocks per pixel; must be ≥2
- SCALE_LOG2, 1, framebuffer is (H_ACTIVE>>S)x(V_ACTIVE>>S)
- ADDR_W, 18, framebuffer address width
- SYNC_POL, 0, asserted level of h_sync and v_sync

Ports:
- clk_50Mhz  in  1  system clock
- rst  in  1  asynchronous, active-low reset
- enable  in  1  scan run request
- pattern  in  1  test-pattern select (see Configuration)
- fb_color  in  8  RGB332 read data, valid one clock after fb_addr
- fb_addr  out  ADDR_W  framebuffer read address
- pix_ce  out  1  one-clock pulse per pixel period
- h_sync, v_sync  out  1  sync outputs, registered
- video_on  out  1  registered active-area flag
- pixel_x, pixel_y  out  11  coordinates aligned with the RGB outputs
- red, green, blue  out  8  colour outputs
- frame_start  out  1  one-clock pulse at output pixel (0,0)

## Operation
- Divider counts 0..CLK_DIV-1. pix_ce is high when the count equals CLK_DIV-1.
- Stage 0 holds h_cnt 0..H_TOTAL-1 and v_cnt 0..V_TOTAL-1. Both advance only on pix_ce. v_cnt advances when h_cnt wraps; both wrap to 0.
- Active area: h_cnt<H_ACTIVE and v_cnt<V_ACTIVE.
- Sync window: h_cnt in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC). v_sync uses the same rule with V parameters.
- fb_addr is formed incrementally, with no multiplier:
  - Column = h_cnt>>S.
  - row_base adds FB_W=(H_ACTIVE>>S) at each line wrap where (v_cnt+1)[S-1:0]==0.
  - row_base clears at the frame wrap.
  - fb_addr = row_base + column. It is combinational from stage-0 registers.
- Stage 1 registers on pix_ce: sync, video_on, pixel_x/y, and colour from fb_color.
- Colour expansion:
  - red = {c[7:5],c[7:5],c[7:6]}
  - green = {c[4:2],c[4:2],c[4:3]}
  - blue = {c[1:0],c[1:0],c[1:0],c[1:0]}
- RGB outputs are 0 whenever video_on is 0.
- Run control states:
  - IDLE: counters held at 0, syncs deasserted (!SYNC_POL), pix_ce still toggles. Goes to RUN when enable=1, starting at the next pix_ce.
  - RUN: scanning. When enable falls, goes to DRAIN.
  - DRAIN: finishes the current frame. Goes to IDLE at the frame wrap. enable re-asserted during DRAIN returns to RUN without a break.

## Timing
- Reset values:
  - All counters and row_base are 0; state is IDLE.
  - h_sync and v_sync are !SYNC_POL.
  - video_on, pix_ce, frame_start and RGB are 0; fb_addr is 0.
- Output latency is one pixel (CLK_DIV clocks) from stage-0 coordinates.
- fb_color is sampled CLK_DIV-1 clocks after fb_addr changes. RAM latency must be ≤ CLK_DIV-1.
- frame_start pulses in the clock stage 1 loads (0,0) while in RUN.
- When the frame wrap and a DRAIN exit fall on the same pix_ce, IDLE wins. The next frame starts only if enable=1 at that edge.
- Reset asserted mid-frame clears everything immediately. A new scan starts from (0,0).

## Configuration
- VGA_TEST_PATTERN_EN defined: when pattern=1, the colour source is 8 vertical bars.
  - The bar index increments every H_ACTIVE/8 active pixels and resets each line.
  - Bar colour = {idx[2],idx[2],idx[2], idx[1],idx[1],idx[1], idx[0],idx[0]}.
  - The index is registered in stage 0, keeping the same latency as fb_color.
- Undefined: the pattern port is present but ignored; colour always comes from fb_color.

## Structure
- Package vga_pkg holds:
  - default timing constants for 640x480@60;
  - the run-state enum (IDLE/RUN/DRAIN);
  - the rgb332_expand function.
- One sub-module, vga_pix_div: divider and pix_ce.
- Counters, address generation, state machine and output stage stay in vga_scan_engine.

## Test plan
- Reset: rst=0 mid-line → all outputs at reset values within the same clock. After release with enable=1, first frame_start at pixel (0,0).
- Small timing (H 8/1/2/1, V 4/1/1/1, CLK_DIV=2, S=1): h_sync low for exactly 2 pixels every 12; v_sync low for exactly 1 line every 7.
- Address: same config, pixel (5,3) → fb_addr = 1*4+2 = 6. Rows 0 and 1 both read base 0.
- Colour: fb_color=0xE0 → red=0xFF, green=0, blue=0. During blanking, RGB=0 regardless of fb_color.
- Run control: enable dropped at line 2 → frame completes, then IDLE with syncs inactive. Re-assert during DRAIN → next frame follows with no gap.
- With VGA_TEST_PATTERN_EN and pattern=1: pixel 0 shows black, pixel H_ACTIVE-1 shows 0xFF; fb_color is ignored.
